// File: rtl/sar_search.sv
// Signed binary search that drives probe values to an external comparator until it reports a match.
// Latency: one cycle from Start to first Guess, one cycle from the match to Done; no backpressure, flags sampled every SEARCH cycle.
module sar_search #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         AgrB,
    input  logic         AeqB,
    input  logic         AltB,
    output logic [W-1:0] Guess,
    output logic         Busy,
    output logic         Done,
    output logic         Err,
    output logic [W-1:0] Found,
    output logic [3:0]   Steps
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE, ERROR} state_t;

    localparam int LO_INIT = -(2 ** (W - 1));
    localparam int HI_INIT = (2 ** (W - 1)) - 1;
    localparam logic signed [W:0] ONE = (W + 1)'(1);

    state_t              state, state_d;
    logic signed [W:0]   lo, hi, lo_d, hi_d;
    logic signed [W:0]   mid, mid_m1, mid_p1;
    logic [3:0]          cnt, cnt_d;
    logic [W-1:0]        found_d;
    logic [3:0]          steps_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            lo    <= '0;
            hi    <= '0;
            cnt   <= '0;
            Found <= '0;
            Steps <= '0;
        end else begin
            state <= state_d;
            lo    <= lo_d;
            hi    <= hi_d;
            cnt   <= cnt_d;
            Found <= found_d;
            Steps <= steps_d;
        end
    end

    always_comb begin
        // One extra bit on lo/hi keeps the sum and the +/-1 updates free of overflow.
        mid     = (lo + hi) >>> 1;
        mid_m1  = mid - ONE;
        mid_p1  = mid + ONE;
        state_d = state;
        lo_d    = lo;
        hi_d    = hi;
        cnt_d   = cnt;
        found_d = Found;
        steps_d = Steps;
        Guess   = '0;
        Busy    = 1'b0;
        Done    = 1'b0;
        Err     = 1'b0;

        case (state)
            IDLE, ERROR: begin
                Err = (state == ERROR);
                if (Start) begin
                    state_d = SEARCH;
                    lo_d    = (W + 1)'(LO_INIT);
                    hi_d    = (W + 1)'(HI_INIT);
                    cnt_d   = '0;
                    found_d = '0;
                    steps_d = '0;
                end
            end
            SEARCH: begin
                Busy  = 1'b1;
                Guess = W'(mid);
                cnt_d = cnt + 4'd1;
                if (!$onehot({AgrB, AeqB, AltB})) begin
                    state_d = ERROR;
                end else if (AeqB) begin
                    state_d = DONE;
                    found_d = W'(mid);
                    steps_d = cnt + 4'd1;
                end else if (AgrB) begin
                    // An empty interval means the comparator contradicted an earlier answer.
                    if (mid_m1 < lo) state_d = ERROR;
                    else             hi_d    = mid_m1;
                end else begin
                    if (mid_p1 > hi) state_d = ERROR;
                    else             lo_d    = mid_p1;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (W=4): comparator modelled from a hidden target, hand-computed guess sequences.
module tb_sar_search;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       AgrB, AeqB, AltB;
    logic [3:0] Guess;
    logic       Busy, Done, Err;
    logic [3:0] Found;
    logic [3:0] Steps;

    int   target;
    logic cmp_auto;
    logic m_gt, m_eq, m_lt;
    int   n_chk;
    int   n_pass;
    int   seq [9];

    sar_search #(.W(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .AgrB  (AgrB),
        .AeqB  (AeqB),
        .AltB  (AltB),
        .Guess (Guess),
        .Busy  (Busy),
        .Done  (Done),
        .Err   (Err),
        .Found (Found),
        .Steps (Steps)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        if (cmp_auto) begin
            AgrB = ($signed(Guess) > target);
            AeqB = ($signed(Guess) == target);
            AltB = ($signed(Guess) < target);
        end else begin
            AgrB = m_gt;
            AeqB = m_eq;
            AltB = m_lt;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Starts a search, follows the expected guesses and stops in the DONE cycle.
    task automatic run(input string nm, input int tgt, input int n, input int steps_exp);
        target   = tgt;
        cmp_auto = 1'b1;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s guess%0d", nm, i), $signed(Guess), seq[i]);
            chk($sformatf("%s busy%0d", nm, i), Busy, 1);
            chk($sformatf("%s done%0d", nm, i), Done, 0);
            tick();
        end
        chk({nm, " done"}, Done, 1);
        chk({nm, " busy_off"}, Busy, 0);
        chk({nm, " found"}, $signed(Found), tgt);
        chk({nm, " steps"}, Steps, steps_exp);
        chk({nm, " guess_idle"}, Guess, 0);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        Reset    = 1'b1;
        Start    = 1'b0;
        cmp_auto = 1'b1;
        m_gt     = 1'b0;
        m_eq     = 1'b0;
        m_lt     = 1'b0;
        target   = 0;
        tick();
        chk("rst guess", Guess, 0);
        chk("rst busy", Busy, 0);
        chk("rst done", Done, 0);
        chk("rst err", Err, 0);
        chk("rst found", Found, 0);
        chk("rst steps", Steps, 0);
        Reset = 1'b0;
        tick();
        chk("idle busy", Busy, 0);

        // Target 7: longest path, W+1 comparisons. Start asserted in DONE is ignored.
        seq = '{-1, 3, 5, 6, 7, 0, 0, 0, 0};
        run("t7", 7, 5, 5);
        Start = 1'b1;
        tick();
        chk("t7 done_pulse", Done, 0);
        chk("t7 start_in_done", Busy, 0);
        chk("t7 found_hold", Found, 7);
        Start = 1'b0;
        tick();
        chk("t7 found_hold2", Found, 7);
        chk("t7 steps_hold", Steps, 5);

        // Target -8: lower boundary.
        seq = '{-1, -5, -7, -8, 0, 0, 0, 0, 0};
        run("tm8", -8, 4, 4);
        chk("tm8 found_raw", Found, 4'b1000);
        tick();

        // Target -1: first probe matches, Busy for exactly one cycle.
        seq = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
        run("tm1", -1, 1, 1);
        tick();
        chk("tm1 done_off", Done, 0);

        // Contradictory flags on the first SEARCH cycle.
        cmp_auto = 1'b0;
        m_gt     = 1'b1;
        m_lt     = 1'b1;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        chk("err busy_first", Busy, 1);
        tick();
        chk("err err", Err, 1);
        chk("err busy", Busy, 0);
        chk("err found", Found, 0);
        chk("err guess", Guess, 0);
        chk("err done", Done, 0);
        tick();
        chk("err held", Err, 1);
        m_gt = 1'b0;
        m_lt = 1'b0;
        seq = '{-1, 3, 0, 0, 0, 0, 0, 0, 0};
        run("t3", 3, 2, 2);
        chk("t3 err_off", Err, 0);
        tick();

        // Start held through SEARCH, then reset between edges in the third SEARCH cycle.
        target   = 7;
        cmp_auto = 1'b1;
        Start    = 1'b1;
        tick();
        chk("rs guess0", $signed(Guess), -1);
        tick();
        chk("rs guess1", $signed(Guess), 3);
        tick();
        chk("rs guess2", $signed(Guess), 5);
        chk("rs busy2", Busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("rs async guess", Guess, 0);
        chk("rs async busy", Busy, 0);
        chk("rs async done", Done, 0);
        chk("rs async found", Found, 0);
        chk("rs async steps", Steps, 0);
        Start = 1'b0;
        tick();
        Reset = 1'b0;
        chk("rs held done", Done, 0);
        tick();
        chk("rs after done", Done, 0);
        chk("rs after busy", Busy, 0);
        tick();
        chk("rs idle busy", Busy, 0);
        chk("rs idle guess", Guess, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 The module SHALL have parameter W, default 4, meaning the signed two's-complement operand width; legal range 2..8.
REQ-002 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port Start, input, 1 bit: request a new search, sampled only in IDLE and ERROR.
REQ-005 The module SHALL have ports AgrB, AeqB and AltB, inputs, 1 bit each: external comparator result for Guess versus the hidden target (Guess>target, Guess==target, Guess<target).
REQ-006 The module SHALL have port Guess, output, W bits: the signed probe value driven to the external comparator.
REQ-007 The module SHALL have ports Busy, Done and Err, outputs, 1 bit each: search in progress, one-cycle completion pulse, and protocol error, respectively.
REQ-008 The module SHALL have port Found, output, W bits: the located target value, held until the next search starts.
REQ-009 The module SHALL have port Steps, output, 4 bits: the number of comparisons consumed by the last successful search.

Function
REQ-010 The module SHALL implement FSM states IDLE, SEARCH, DONE and ERROR.
REQ-011 In IDLE, Start=1 at an edge SHALL load lo=-2^(W-1) and hi=2^(W-1)-1, clear the step counter, clear Found and Steps, and move to SEARCH.
REQ-012 lo, hi and the midpoint arithmetic SHALL use W+1-bit signed registers, so no overflow occurs.
REQ-013 In SEARCH, Guess SHALL equal (lo+hi)>>>1 (floor), computed combinationally from registers; outside SEARCH, Guess SHALL be 0.
REQ-014 In SEARCH, each edge SHALL sample the comparator flags and increment the step counter.
REQ-015 On an exactly-one-hot flag sample, AgrB SHALL set hi=Guess-1, AltB SHALL set lo=Guess+1, and AeqB SHALL load Found=Guess and Steps=count+1 and move to DONE.
REQ-016 In SEARCH, a flag sample that is not exactly one-hot (zero or multiple flags high) SHALL move to ERROR with lo/hi unchanged.
REQ-017 In SEARCH, if an update would make lo>hi (inconsistent or moving target), the state SHALL go to ERROR instead of SEARCH.
REQ-018 Busy SHALL be 1 exactly in SEARCH.
REQ-019 Done SHALL be 1 exactly in DONE, which lasts one cycle and then moves unconditionally to IDLE; Start in DONE SHALL be ignored.
REQ-020 Err SHALL be 1 exactly in ERROR; ERROR SHALL remain until Start=1, which behaves as REQ-011 (Err drops the next cycle).
REQ-021 Start in SEARCH SHALL be ignored, and the current search SHALL continue undisturbed.
REQ-022 The maximum search length SHALL be W+1 comparisons; latency SHALL be one cycle from Start to the first Guess, and one cycle from the AeqB sample to Done.

Reset
REQ-023 Reset=1 SHALL immediately, without waiting for Clk, force IDLE with Guess=0, Busy=0, Done=0, Err=0, Found=0, Steps=0, lo=0, hi=0 and counter=0.
REQ-024 Reset asserted mid-SEARCH SHALL abort the search with no Done pulse; the first search after Reset deasserts SHALL require a new Start.

Verification
REQ-025 A bench SHALL cover, with W=4 and target 7: Start -> Guess sequence -1,3,5,6,7; Done pulses one cycle; Found=7; Steps=5.
REQ-026 A bench SHALL cover, with W=4 and target -8: Start -> Guess sequence -1,-5,-7,-8; Found=-8 (4'b1000); Steps=4.
REQ-027 A bench SHALL cover, with W=4 and target -1: Start -> first Guess=-1 matches; Done on the next cycle; Steps=1; Busy high for exactly one cycle.
REQ-028 A bench SHALL cover AgrB=1 together with AltB=1 during the first SEARCH cycle -> ERROR, Err=1, Busy=0, Found=0; a later Start with a consistent comparator and target 3 -> Found=3.
REQ-029 A bench SHALL cover Reset pulsed between clock edges during the third SEARCH cycle -> outputs zero immediately with no Done; Start held during SEARCH has no effect on the Guess sequence.
